// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwmin in prescaled ticks and
// reports them with a one-cycle valid strobe; flags a sticky timeout on stalls.
module pwm_capture #(
  parameter int CW          = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [14:0]   finalv,
  input  logic          pwmin,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          timeout
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic [14:0]            pre_q, pre_d;
  logic [CW-1:0]          per_cnt_q, per_cnt_d;
  logic [CW-1:0]          hi_cnt_q, hi_cnt_d;
  logic [CW-1:0]          duty_q, duty_d;
  logic [CW-1:0]          period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic                   lvl, rise, tick;
  logic [CW-1:0]          tick_ext;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) return v + {{(CW-1){1'b0}}, 1'b1};
    return v;
  endfunction

  assign lvl      = sync_q[SYNC_STAGES-1];
  assign rise     = lvl & ~dly_q;
  // >= rather than == so a shrinking finalv cannot strand the count above it
  assign tick     = (pre_q >= finalv);
  assign tick_ext = {{(CW-1){1'b0}}, tick};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      dly_q     <= 1'b0;
      state_q   <= IDLE;
      pre_q     <= '0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pwmin};
      dly_q     <= lvl;
      state_q   <= state_d;
      pre_q     <= pre_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!enable) begin
      state_d   = IDLE;
      pre_d     = '0;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      pre_d = tick ? 15'd0 : pre_q + 15'd1;
      case (state_q)
        IDLE: begin
          pre_d     = '0;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          state_d   = ARM;
        end
        ARM: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          if (rise) begin
            state_d   = MEASURE;
            per_cnt_d = tick_ext;
            hi_cnt_d  = tick_ext;
          end
        end
        MEASURE: begin
          if (rise) begin
            // the tick coinciding with the edge belongs to the new period
            duty_d    = hi_cnt_q;
            period_d  = per_cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            per_cnt_d = tick_ext;
            hi_cnt_d  = tick_ext;
          end else if (per_cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            period_d  = CNT_MAX;
            duty_d    = lvl ? CNT_MAX : '0;
            valid_d   = 1'b1;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            state_d   = ARM;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q, tick);
            hi_cnt_d  = sat_inc(hi_cnt_q, tick & lvl);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign duty    = duty_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven periodic waveforms, directed corner
// sequences, and a random waveform scored against a window-sum reference.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CW   = 10;
  localparam int MAXV = (1 << CW) - 1;
  localparam int HLEN = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [14:0]   finalv = '0;
  logic          pwmin = 1'b0;
  logic [CW-1:0] duty, period;
  logic          valid, timeout;

  pwm_capture #(.CW(CW), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .finalv (finalv),
    .pwmin  (pwmin),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fv;
    int hi;
    int per;
    int exp_duty;
    int exp_per;
  } vec_t;

  vec_t vecs[6];

  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;
  int   cap_at[$], cap_duty[$], cap_per[$], cap_to[$];
  logic drv_hist[HLEN];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_caps();
    cap_at.delete();
    cap_duty.delete();
    cap_per.delete();
    cap_to.delete();
  endtask

  // one clock: drive pwmin just after the edge, observe outputs mid-cycle
  task automatic cyc(input logic p);
    pwmin = p;
    if (cyc_n < HLEN) drv_hist[cyc_n] = p;
    @(negedge clk);
    if (valid === 1'b1) begin
      cap_at.push_back(cyc_n);
      cap_duty.push_back(int'(duty));
      cap_per.push_back(int'(period));
      cap_to.push_back(int'(timeout));
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  task automatic run_pwm(input int hi, input int per, input int n);
    repeat (n) begin
      repeat (hi) cyc(1'b1);
      repeat (per - hi) cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pwmin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc_n = 0;
    clear_caps();
  endtask

  function automatic bit lvl_at(input int m);
    return (m >= 2) ? drv_hist[m-2] : 1'b0;
  endfunction

  function automatic bit tick_at(input int m, input int fv);
    return (m >= 1) && (((m - 1) % (fv + 1)) == fv);
  endfunction

  initial begin
    int t0, fvr, n, p, d;
    int rises[$];

    vecs[0] = '{0,  64,  256,  64, 256};
    vecs[1] = '{3, 256, 1024,  64, 256};
    vecs[2] = '{1,  30,  100,  15,  50};
    vecs[3] = '{0,   1,    2,   1,   2};
    vecs[4] = '{2,   9,   30,   3,  10};
    vecs[5] = '{4, 500, 1000, 100, 200};

    repeat (2) @(posedge clk);
    #1;
    chk("reset duty", int'(duty), 0);
    chk("reset period", int'(period), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset timeout", int'(timeout), 0);

    foreach (vecs[k]) begin
      do_reset();
      finalv = 15'(vecs[k].fv);
      enable = 1'b1;
      idle(8);
      run_pwm(vecs[k].hi, vecs[k].per, 4);
      idle(8);
      chk($sformatf("v%0d valid count", k), cap_at.size(), 3);
      if (cap_at.size() > 0)
        chk($sformatf("v%0d first valid cycle", k), cap_at[0], 8 + vecs[k].per + 3);
      for (int i = 0; i < cap_at.size() && i < 3; i++) begin
        chk($sformatf("v%0d duty[%0d]", k, i), cap_duty[i], vecs[k].exp_duty);
        chk($sformatf("v%0d period[%0d]", k, i), cap_per[i], vecs[k].exp_per);
        chk($sformatf("v%0d timeout[%0d]", k, i), cap_to[i], 0);
        if (i > 0)
          chk($sformatf("v%0d valid spacing[%0d]", k, i), cap_at[i] - cap_at[i-1], vecs[k].per);
      end
    end

    // finalv shrinks 3 -> 1 in mid-period; next full period is in the new tick size
    do_reset();
    finalv = 15'd3;
    enable = 1'b1;
    idle(8);
    run_pwm(256, 1024, 2);
    repeat (256) cyc(1'b1);
    repeat (244) cyc(1'b0);
    finalv = 15'd1;
    repeat (524) cyc(1'b0);
    run_pwm(256, 1024, 2);
    idle(8);
    chk("fv change valid count", cap_at.size(), 4);
    if (cap_at.size() >= 4) begin
      chk("fv change period before", cap_per[1], 256);
      chk("fv change duty before", cap_duty[1], 64);
      chk("fv change period after", cap_per[3], 512);
      chk("fv change duty after", cap_duty[3], 128);
    end

    // 100% duty: timeout with duty=period=MAX, then recovery
    do_reset();
    finalv = 15'd0;
    enable = 1'b1;
    idle(8);
    t0 = cyc_n;
    repeat (1100) cyc(1'b1);
    chk("hi timeout valid count", cap_at.size(), 1);
    if (cap_at.size() > 0) begin
      chk("hi timeout latency", cap_at[0] - t0, 1026);
      chk("hi timeout duty", cap_duty[0], MAXV);
      chk("hi timeout period", cap_per[0], MAXV);
      chk("hi timeout flag", cap_to[0], 1);
    end
    idle(20);
    clear_caps();
    run_pwm(30, 100, 1);
    chk("timeout sticky", int'(timeout), 1);
    chk("no valid on rearm rise", cap_at.size(), 0);
    run_pwm(30, 100, 2);
    idle(8);
    chk("recover valid count", cap_at.size(), 2);
    if (cap_at.size() > 0) begin
      chk("recover duty", cap_duty[0], 30);
      chk("recover period", cap_per[0], 100);
      chk("recover timeout clear", cap_to[0], 0);
    end

    // 0% duty after a short pulse
    do_reset();
    finalv = 15'd0;
    enable = 1'b1;
    idle(8);
    t0 = cyc_n;
    repeat (5) cyc(1'b1);
    repeat (1100) cyc(1'b0);
    chk("lo timeout valid count", cap_at.size(), 1);
    if (cap_at.size() > 0) begin
      chk("lo timeout latency", cap_at[0] - t0, 1026);
      chk("lo timeout duty", cap_duty[0], 0);
      chk("lo timeout period", cap_per[0], MAXV);
      chk("lo timeout flag", cap_to[0], 1);
    end

    // asynchronous reset in mid-period
    do_reset();
    finalv = 15'd1;
    enable = 1'b1;
    idle(8);
    run_pwm(30, 100, 3);
    repeat (20) cyc(1'b1);
    repeat (20) cyc(1'b0);
    chk("pre-reset duty", int'(duty), 15);
    reset = 1'b0;
    #2;
    chk("async reset duty", int'(duty), 0);
    chk("async reset period", int'(period), 0);
    chk("async reset valid", int'(valid), 0);
    chk("async reset timeout", int'(timeout), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc_n = 0;
    clear_caps();
    idle(5);
    run_pwm(30, 100, 1);
    chk("post-reset no early valid", cap_at.size(), 0);
    run_pwm(30, 100, 1);
    idle(5);
    chk("post-reset valid count", cap_at.size(), 1);
    if (cap_at.size() > 0) begin
      chk("post-reset valid cycle", cap_at[0], 5 + 100 + 3);
      chk("post-reset duty", cap_duty[0], 15);
      chk("post-reset period", cap_per[0], 50);
    end

    // enable low for 10 clocks: outputs hold, no strobes
    clear_caps();
    enable = 1'b0;
    repeat (5) cyc(1'b1);
    repeat (5) cyc(1'b0);
    chk("disabled no valid", cap_at.size(), 0);
    chk("disabled duty hold", int'(duty), 15);
    chk("disabled period hold", int'(period), 50);
    enable = 1'b1;
    t0 = cyc_n;
    idle(5);
    run_pwm(30, 100, 2);
    idle(5);
    chk("re-enable valid count", cap_at.size(), 1);
    if (cap_at.size() > 0)
      chk("re-enable valid cycle", cap_at[0] - t0, 5 + 100 + 3);

    // random waveform against the window-sum reference
    do_reset();
    fvr = $urandom_range(3, 0);
    finalv = 15'(fvr);
    enable = 1'b1;
    idle(6);
    repeat (25) begin
      repeat ($urandom_range(40, 1)) cyc(1'b1);
      repeat ($urandom_range(40, 1)) cyc(1'b0);
    end
    idle(6);
    n = cyc_n;
    rises.delete();
    for (int m = 1; m < n; m++)
      if (lvl_at(m) && !lvl_at(m - 1)) rises.push_back(m);
    chk("rand valid count", cap_at.size(), rises.size() - 1);
    for (int i = 1; i < rises.size() && i <= cap_at.size(); i++) begin
      p = 0;
      d = 0;
      for (int m = rises[i-1]; m < rises[i]; m++) begin
        if (tick_at(m, fvr)) begin
          p++;
          if (lvl_at(m)) d++;
        end
      end
      if (p > MAXV) p = MAXV;
      if (d > MAXV) d = MAXV;
      chk($sformatf("rand valid cycle[%0d]", i), cap_at[i-1], rises[i] + 1);
      chk($sformatf("rand duty[%0d]", i), cap_duty[i-1], d);
      chk($sformatf("rand period[%0d]", i), cap_per[i-1], p);
      chk($sformatf("rand timeout[%0d]", i), cap_to[i-1], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: high time and period, counted in prescaled ticks.
- Tick convention matches the team's PWM generator (tick every finalv+1 clocks), so a loopback of generator output reproduces the programmed duty and period counts.
- Sits on the receive side of PWM links; feeds duty and period to control logic with a one-cycle valid strobe.

Parameters:
- CW, 10, width of the high-time and period counters and outputs; saturation value 2^CW-1.
- SYNC_STAGES, 2, synchronizer flops on pwmin; minimum 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable.
- finalv  input  15  prescaler terminal count; tick period is finalv+1 clocks.
- pwmin  input  1  asynchronous PWM input.
- duty  output  CW  measured high ticks of the last complete period.
- period  output  CW  measured ticks of the last complete period, rising edge to rising edge.
- valid  output  1  one-clock strobe; duty/period updated this cycle.
- timeout  output  1  sticky; counter saturated with no rising edge.

Behaviour:
- Reset (reset=0, asynchronous): duty=0, period=0, valid=0, timeout=0, synchronizer=0, prescaler=0, counters=0, state=IDLE.
- Synchronizer: SYNC_STAGES flops, then a delay flop. rise = synced & ~delayed. lvl = synced.
- Prescaler:
  - Counts clocks while enable=1.
  - tick=1 and prescaler returns to 0 when the count is >= finalv. The >= comparison avoids runaway if finalv shrinks mid-count.
  - finalv=0 gives a tick every clock.
- State machine:
  - IDLE: entered on reset or enable=0. Prescaler and counters are cleared; duty/period/timeout hold; valid=0. Goes to ARM when enable=1.
  - ARM: counters are held at 0. Goes to MEASURE on the first rise. No valid for this partial period.
  - MEASURE: on tick, per_cnt+1 and, if lvl=1, hi_cnt+1. Both saturate at 2^CW-1. Transitions:
    - On rise: duty<=hi_cnt, period<=per_cnt (values before this cycle's update), valid=1, timeout<=0. The counters restart: per_cnt<=tick, hi_cnt<=tick. A simultaneous tick is counted into the new period.
    - When per_cnt reaches 2^CW-1 with no rise: timeout<=1, period<=2^CW-1, duty<=(lvl ? 2^CW-1 : 0), valid=1 once. Go to ARM.
    - enable=0 goes to IDLE from any state within one clock.
- Latency: valid asserts 3 clocks after the first clk edge that samples pwmin high (SYNC_STAGES=2).
- duty <= period always holds.
- Pulses shorter than one clock may be missed. Glitches of one or more clocks are measured as real edges; no filtering.
- Reset mid-measurement: immediate return to reset values. The first valid comes no earlier than the second rise after release.
- Duty of 0% or 100% (no edges) is reported only through the timeout path.

Test Plan:
- finalv=0, pwmin period 256 clk with 64 clk high, 4 periods -> first valid after the 2nd rise, plus 3 clk; duty=64, period=256; valid one cycle each period; timeout=0.
- finalv=3, pwmin period 1024 clk with 256 clk high -> duty=64, period=256. Then change finalv to 1 mid-period -> no hang; the following full period reports period=512.
- CW=10, finalv=0, pwmin held high after one rise -> after 1023 ticks: valid, timeout=1, duty=1023, period=1023. Then resume 100-clk period with 30 high -> timeout clears on the first valid, duty=30, period=100.
- pwmin held low after a rise (0%) -> timeout=1, duty=0, period=1023.
- Assert reset low mid-period, then release -> outputs 0 immediately, and no valid until the second rise after release. Repeat with enable=0 for 10 clk: outputs hold their last values and valid=0.
- Rise coincident with tick (finalv=0) -> previous period excludes that tick, and the new period begins at per_cnt=1.
